// File: rtl/ddr4_v2_2_20_carry_latch_reduce.sv
// rtl/ddr4_v2_2_20_carry_latch_reduce.sv - pipelined OR/AND carry reduction with valid/ready and optional sticky latch
module ddr4_v2_2_20_carry_latch_reduce #(
  parameter     C_FAMILY    = "virtex6",
  parameter int C_WIDTH     = 32,
  parameter int C_SEG_WIDTH = 8,
  parameter     C_MODE      = "OR",
  parameter int C_STICKY    = 0
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               S_VALID,
  output logic               S_READY,
  input  logic               S_CIN,
  input  logic [C_WIDTH-1:0] S_DATA,
  input  logic               CLEAR,
  output logic               M_VALID,
  input  logic               M_READY,
  output logic               M_O
);

  localparam int   NSEG   = (C_WIDTH + C_SEG_WIDTH - 1) / C_SEG_WIDTH;
  localparam int   PW     = NSEG * C_SEG_WIDTH;
  localparam bit   IS_AND = (C_MODE == "AND");
  localparam logic ID     = IS_AND;
  localparam       unused_family = C_FAMILY;

  if (C_MODE != "OR" && C_MODE != "AND") begin : g_bad_mode
    $error("C_MODE must be \"OR\" or \"AND\"");
  end

  // Bit offset of stage k's leftover (not yet reduced) segments in dflat.
  function automatic int off(input int k);
    return k * PW - (C_SEG_WIDTH * k * (k + 1)) / 2;
  endfunction

  localparam int TD = off(NSEG - 1);
  localparam int DW = (TD > 0) ? TD : 1;

  function automatic logic op(input logic a, input logic b);
    return IS_AND ? (a & b) : (a | b);
  endfunction

  function automatic logic red(input logic [C_SEG_WIDTH-1:0] s);
    return IS_AND ? (&s) : (|s);
  endfunction

  logic [PW-1:0]   s_pad;
  logic [DW-1:0]   dflat;
  logic [NSEG-1:0] v_q, c_q, acc, vprev, cprev, red_k;
  logic            res;

  // Pad the tail of the last segment with the operator identity.
  always_comb begin
    s_pad              = {PW{ID}};
    s_pad[C_WIDTH-1:0] = S_DATA;
  end

  // acc[k]: stage k may load this cycle (empty, or its contents move on).
  always_comb begin
    logic chain;
    acc   = '0;
    chain = M_READY;
    for (int k = NSEG - 1; k >= 0; k--) begin
      chain  = !v_q[k] || chain;
      acc[k] = chain;
    end
  end

  always_comb begin
    vprev    = '0;
    cprev    = '0;
    vprev[0] = S_VALID;
    cprev[0] = S_CIN;
    for (int k = 1; k < NSEG; k++) begin
      vprev[k] = v_q[k-1];
      cprev[k] = c_q[k-1];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int WIN  = PW - k * C_SEG_WIDTH;
    localparam int WOUT = WIN - C_SEG_WIDTH;
    logic [WIN-1:0] src;

    if (k == 0) begin : g_src0
      assign src = s_pad;
    end else begin : g_srcn
      assign src = dflat[off(k-1) +: WIN];
    end

    assign red_k[k] = red(src[C_SEG_WIDTH-1:0]);

    if (WOUT > 0) begin : g_d
      logic [WOUT-1:0] d;
      always_ff @(posedge ACLK) begin
        if (acc[k]) d <= src[WIN-1:C_SEG_WIDTH];
      end
      assign dflat[off(k) +: WOUT] = d;
    end
  end

  if (NSEG == 1) begin : g_single
    logic unused_dflat;
    assign dflat        = '0;
    assign unused_dflat = dflat[0];
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      v_q <= '0;
      c_q <= {NSEG{ID}};
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        if (acc[k]) begin
          v_q[k] <= vprev[k];
          c_q[k] <= op(cprev[k], red_k[k]);
        end
      end
    end
  end

  assign S_READY = !ARESET && acc[0];
  assign M_VALID = v_q[NSEG-1];
  assign res     = c_q[NSEG-1];

  if (C_STICKY != 0) begin : g_sticky
    logic l_q, hs;
    assign hs = M_VALID && M_READY;
    // A clear on the handshake cycle wipes history but keeps this result.
    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)           l_q <= ID;
      else if (CLEAR && hs) l_q <= res;
      else if (CLEAR)       l_q <= ID;
      else if (hs)          l_q <= op(l_q, res);
    end
    assign M_O = op(l_q, res);
  end else begin : g_plain
    logic unused_clear;
    assign unused_clear = CLEAR;
    assign M_O          = res;
  end

endmodule

// File: tb/tb_ddr4_v2_2_20_carry_latch_reduce.sv
// tb/tb_ddr4_v2_2_20_carry_latch_reduce.sv - directed and randomized checks of the carry latch reducer
module tb_ddr4_v2_2_20_carry_latch_reduce;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic        v1, r1, cin1, mv1, mr1, mo1, clr0;
  logic [31:0] d1;
  logic        v2, r2, cin2, mv2, mr2, mo2;
  logic [19:0] d2;
  logic        v3, r3, cin3, mv3, mr3, mo3, clr3;
  logic [31:0] d3;
  logic        rand_go;

  ddr4_v2_2_20_carry_latch_reduce #(.C_FAMILY("virtex6"), .C_WIDTH(32), .C_SEG_WIDTH(8),
    .C_MODE("OR"), .C_STICKY(0)) u_or (
    .ACLK(clk), .ARESET(rst), .S_VALID(v1), .S_READY(r1), .S_CIN(cin1), .S_DATA(d1),
    .CLEAR(clr0), .M_VALID(mv1), .M_READY(mr1), .M_O(mo1));

  ddr4_v2_2_20_carry_latch_reduce #(.C_FAMILY("virtex6"), .C_WIDTH(20), .C_SEG_WIDTH(8),
    .C_MODE("AND"), .C_STICKY(0)) u_and (
    .ACLK(clk), .ARESET(rst), .S_VALID(v2), .S_READY(r2), .S_CIN(cin2), .S_DATA(d2),
    .CLEAR(clr0), .M_VALID(mv2), .M_READY(mr2), .M_O(mo2));

  ddr4_v2_2_20_carry_latch_reduce #(.C_FAMILY("virtex6"), .C_WIDTH(32), .C_SEG_WIDTH(8),
    .C_MODE("OR"), .C_STICKY(1)) u_sticky (
    .ACLK(clk), .ARESET(rst), .S_VALID(v3), .S_READY(r3), .S_CIN(cin3), .S_DATA(d3),
    .CLEAR(clr3), .M_VALID(mv3), .M_READY(mr3), .M_O(mo3));

  localparam int RW [4] = '{1, 7, 64, 32};
  localparam int RS [4] = '{1, 3, 8, 3};
  localparam int RA [4] = '{0, 1, 0, 1};

  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int W = RW[g];
    logic         v, rdy, ci, mv, mr, mo;
    logic [W-1:0] d;
    logic         q [$];

    ddr4_v2_2_20_carry_latch_reduce #(.C_FAMILY("virtex6"), .C_WIDTH(W), .C_SEG_WIDTH(RS[g]),
      .C_MODE(RA[g] ? "AND" : "OR"), .C_STICKY(0)) u_dut (
      .ACLK(clk), .ARESET(rst), .S_VALID(v), .S_READY(rdy), .S_CIN(ci), .S_DATA(d),
      .CLEAR(1'b0), .M_VALID(mv), .M_READY(mr), .M_O(mo));

    initial begin
      logic        hold, held, e;
      logic [63:0] r64;
      int          idx;
      v = 0; mr = 0; ci = 0; d = '0; hold = 0; held = 0;
      wait (rand_go);
      for (int cyc = 0; cyc < 440; cyc++) begin
        if (cyc < 400) begin
          v   = ($urandom_range(0, 3) != 0);
          mr  = ($urandom_range(0, 2) != 0);
          ci  = RA[g] ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0);
          r64 = {$urandom, $urandom};
          idx = $urandom_range(0, W - 1);
          case ($urandom_range(0, 2))
            0: d = RA[g] ? '1 : '0;
            1: begin d = RA[g] ? '1 : '0; d[idx] = ~d[idx]; end
            default: d = r64[W-1:0];
          endcase
        end else begin
          v  = 0;
          mr = 1;
        end
        #1;
        if (hold) begin
          check("rnd_hold_valid", mv, 1);
          check("rnd_hold_o", mo, held);
        end
        if (v && rdy) q.push_back(RA[g] ? (ci & (&d)) : (ci | (|d)));
        if (mv && mr) begin
          if (q.size() == 0) check("rnd_extra_out", mv, 0);
          else begin
            e = q.pop_front();
            check("rnd_o", mo, e);
          end
        end
        hold = mv && !mr;
        held = mo;
        @(posedge clk); #1;
      end
      check("rnd_left", q.size(), 0);
    end
  end

  logic [31:0] t1d [3] = '{32'h0, 32'h0001_0000, 32'h0};
  logic        t1c [3] = '{1'b0, 1'b0, 1'b1};
  logic        t1o [3] = '{1'b0, 1'b1, 1'b1};
  logic [19:0] t2d [2] = '{20'hFFFFF, 20'hFFF7F};
  logic        t2o [2] = '{1'b1, 1'b0};
  logic [31:0] t3d [6] = '{32'h1, 32'h0, 32'h8000_0000, 32'h0, 32'hFFFF, 32'hFFFF};
  logic        t3c [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic        t3o [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  task automatic sticky_txn(input logic [31:0] d, input logic clr, input logic exp_o);
    int n;
    v3 = 1; d3 = d; cin3 = 0;
    @(posedge clk); #1;
    v3 = 0;
    n = 0;
    while (!mv3 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("st_valid", mv3, 1);
    check("st_mo", mo3, exp_o);
    clr3 = clr;
    @(posedge clk); #1;
    clr3 = 0;
  endtask

  initial begin
    int acc_n;
    rst = 1; rand_go = 0; clr0 = 0; clr3 = 0;
    v1 = 0; cin1 = 0; d1 = '0; mr1 = 0;
    v2 = 0; cin2 = 0; d2 = '0; mr2 = 0;
    v3 = 0; cin3 = 0; d3 = '0; mr3 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sready_or", r1, 0);
    check("rst_mvalid_or", mv1, 0);
    check("rst_mo_or", mo1, 0);
    check("rst_sready_and", r2, 0);
    check("rst_mo_and", mo2, 1);
    check("rst_sready_st", r3, 0);
    check("rst_mo_st", mo3, 0);
    rst = 0;
    #1;
    check("rel_sready", r1, 1);

    mr1 = 1;
    for (int i = 0; i < 8; i++) begin
      v1 = (i < 3);
      if (i < 3) begin d1 = t1d[i]; cin1 = t1c[i]; end
      else begin d1 = '0; cin1 = 0; end
      #1;
      check("or_sready", r1, 1);
      @(posedge clk); #1;
      check("or_mvalid", mv1, (i >= 3 && i <= 5));
      if (i >= 3 && i <= 5) check("or_mo", mo1, t1o[i-3]);
    end

    mr2 = 1;
    for (int i = 0; i < 6; i++) begin
      v2 = (i < 2);
      d2 = (i < 2) ? t2d[i] : '0;
      cin2 = 1;
      @(posedge clk); #1;
      check("and_mvalid", mv2, (i >= 2 && i <= 3));
      if (i >= 2 && i <= 3) check("and_mo", mo2, t2o[i-2]);
    end
    v2 = 0;

    mr1 = 0;
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      v1 = 1; d1 = t3d[i]; cin1 = t3c[i];
      #1;
      if (r1) acc_n++;
      @(posedge clk); #1;
    end
    v1 = 0;
    check("bp_accepted", acc_n, 4);
    check("bp_sready", r1, 0);
    for (int i = 0; i < 3; i++) begin
      check("bp_stall_valid", mv1, 1);
      check("bp_stall_o", mo1, t3o[0]);
      @(posedge clk); #1;
    end
    mr1 = 1;
    for (int i = 0; i < 4; i++) begin
      check("bp_drain_valid", mv1, 1);
      check("bp_drain_o", mo1, t3o[i]);
      @(posedge clk); #1;
    end
    check("bp_empty", mv1, 0);

    mr3 = 1;
    sticky_txn(32'h0, 0, 0);
    sticky_txn(32'h0100_0000, 0, 1);
    sticky_txn(32'h0, 0, 1);
    clr3 = 1;
    check("st_clr_idle", mv3, 0);
    @(posedge clk); #1;
    clr3 = 0;
    sticky_txn(32'h0, 0, 0);
    sticky_txn(32'h0100_0000, 0, 1);
    sticky_txn(32'h0, 1, 1);
    sticky_txn(32'h0, 0, 0);
    sticky_txn(32'h0000_0100, 1, 1);
    sticky_txn(32'h0, 0, 1);

    mr1 = 0;
    for (int i = 0; i < 3; i++) begin
      v1 = 1; d1 = 32'h8; cin1 = 0;
      @(posedge clk); #1;
    end
    v1 = 0;
    @(posedge clk); #1;
    check("rst_pre_valid", mv1, 1);
    #2;
    rst = 1;
    #1;
    check("rst_async_valid", mv1, 0);
    check("rst_async_sready", r1, 0);
    check("rst_async_mo", mo1, 0);
    @(posedge clk); #1;
    rst = 0;
    #1;
    check("rst_post_sready", r1, 1);
    mr1 = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("rst_no_stale", mv1, 0);
    end

    rand_go = 1;
    repeat (460) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
